// File: rtl/delay_meas_ctrl.sv
// Delay-measurement sequencer: settles the path under test, launches a rising
// edge, gates the datapath counter until the synchronized path output changes,
// then accumulates the per-trial cycle delta over a programmable trial count.
// Optional min/max delay tracking is enabled by defining DELAY_MEAS_MINMAX_EN.
module delay_meas_ctrl #(
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned TRIALS_W      = 8,
  parameter int unsigned SUM_W         = 40,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TRIALS_W-1:0] num_trials,
  input  logic [CNT_W-1:0]    cnt_value,
  input  logic                path_result,
  output logic                path_input,
  output logic                cnt_ld,
  output logic                busy,
  output logic                done,
  output logic [SUM_W-1:0]    sum_out,
  output logic [TRIALS_W-1:0] trials_done,
  output logic                timeout_err
`ifdef DELAY_MEAS_MINMAX_EN
  ,
  output logic [CNT_W-1:0]    min_delay,
  output logic [CNT_W-1:0]    max_delay
`endif
);

  localparam int unsigned CYC_MAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_RECORD, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic                sync_meta, sync_res;
  logic                baseline;
  logic [CNT_W-1:0]    snapshot;
  logic [TRIALS_W-1:0] num_lat;
  logic [CYC_W-1:0]    cyc_cnt;
  logic                path_input_nx, cnt_ld_nx, busy_nx, done_nx;
  logic [CNT_W-1:0]    delta_c;
  logic [SUM_W:0]      sum_ext_c;
  logic [SUM_W-1:0]    sum_sat_c;

  // Modulo-2^CNT_W delta absorbs a wrap of the datapath counter; sum saturates.
  assign delta_c   = cnt_value - snapshot;
  assign sum_ext_c = {1'b0, sum_out} + (SUM_W+1)'(delta_c);
  assign sum_sat_c = sum_ext_c[SUM_W] ? '1 : sum_ext_c[SUM_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; outputs are decoded from the next state and registered
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = (num_trials == '0) ? S_DONE : S_SETTLE;
      S_SETTLE: if (cyc_cnt == CYC_W'(SETTLE_CYCLES - 1)) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_WAIT;
      S_WAIT: begin
        if (sync_res != baseline)                 state_nx = S_RECORD;
        else if (cyc_cnt == CYC_W'(TIMEOUT - 1))  state_nx = S_DONE;
      end
      S_RECORD: state_nx = ((trials_done + TRIALS_W'(1)) == num_lat) ? S_DONE : S_SETTLE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
    path_input_nx = (state_nx == S_LAUNCH) || (state_nx == S_WAIT) || (state_nx == S_RECORD);
    cnt_ld_nx     = (state_nx == S_LAUNCH) || (state_nx == S_WAIT);
    busy_nx       = (state_nx == S_SETTLE) || (state_nx == S_LAUNCH) ||
                    (state_nx == S_WAIT)   || (state_nx == S_RECORD);
    done_nx       = (state_nx == S_DONE);
  end

  // Two-flop synchronizer for the asynchronous path output
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= 1'b0;
      sync_res  <= 1'b0;
    end else begin
      sync_meta <= path_result;
      sync_res  <= sync_meta;
    end
  end

  // Registered outputs, per-state cycle counter and trial bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      path_input  <= 1'b0;
      cnt_ld      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sum_out     <= '0;
      trials_done <= '0;
      timeout_err <= 1'b0;
      baseline    <= 1'b0;
      snapshot    <= '0;
      num_lat     <= '0;
      cyc_cnt     <= '0;
`ifdef DELAY_MEAS_MINMAX_EN
      min_delay   <= '0;
      max_delay   <= '0;
`endif
    end else begin
      path_input <= path_input_nx;
      cnt_ld     <= cnt_ld_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      if (state_nx != state)  cyc_cnt <= '0;
      else if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + CYC_W'(1);
      case (state)
        S_IDLE: if (start) begin
          num_lat     <= num_trials;
          sum_out     <= '0;
          trials_done <= '0;
          timeout_err <= 1'b0;
`ifdef DELAY_MEAS_MINMAX_EN
          min_delay   <= '1;
          max_delay   <= '0;
`endif
        end
        S_SETTLE: if (state_nx == S_LAUNCH) baseline <= sync_res;
        S_LAUNCH: snapshot <= cnt_value;
        S_WAIT:   if (state_nx == S_DONE) timeout_err <= 1'b1;
        S_RECORD: begin
          sum_out     <= sum_sat_c;
          trials_done <= trials_done + TRIALS_W'(1);
`ifdef DELAY_MEAS_MINMAX_EN
          if (delta_c < min_delay) min_delay <= delta_c;
          if (delta_c > max_delay) max_delay <= delta_c;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_meas_ctrl.sv
// Directed bench for delay_meas_ctrl: a shift-register path model with
// selectable delay/inversion/stuck-at-0 and a cnt_ld-gated 32-bit counter.
module tb_delay_meas_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_trials;
  logic [31:0] cnt_value;
  logic        path_result;
  logic        path_input, cnt_ld, busy, done, timeout_err;
  logic [39:0] sum_out;
  logic [7:0]  trials_done;
`ifdef DELAY_MEAS_MINMAX_EN
  logic [31:0] min_delay, max_delay;
`endif

  int vectors    = 0;
  int miscompares = 0;

  // Path model controls
  int          dly   = 5;
  logic        inv   = 1'b0;
  logic        stuck = 1'b0;
  logic [15:0] pipe;
  logic        preset_req = 1'b0;
  logic [31:0] preset_val = '0;

  always #5 clk = ~clk;

  delay_meas_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_trials(num_trials),
    .cnt_value(cnt_value), .path_result(path_result),
    .path_input(path_input), .cnt_ld(cnt_ld), .busy(busy), .done(done),
    .sum_out(sum_out), .trials_done(trials_done), .timeout_err(timeout_err)
`ifdef DELAY_MEAS_MINMAX_EN
    , .min_delay(min_delay), .max_delay(max_delay)
`endif
  );

  // Path under test: output follows input dly cycles later
  always @(posedge clk) begin
    if (rst) pipe <= '0;
    else     pipe <= {pipe[14:0], path_input};
  end
  assign path_result = stuck ? 1'b0 : (inv ^ pipe[dly-1]);

  // Datapath increment register
  always @(posedge clk) begin
    if (rst)             cnt_value <= '0;
    else if (preset_req) cnt_value <= preset_val;
    else if (cnt_ld)     cnt_value <= cnt_value + 32'd1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) expire(tag);
  endtask

  task automatic wait_cnt_ld(input string tag);
    int n = 0;
    while (cnt_ld !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cnt_ld !== 1'b1) expire(tag);
  endtask

  task automatic wait_trials(input string tag, input logic [7:0] k);
    int n = 0;
    while (trials_done !== k && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (trials_done !== k) expire(tag);
  endtask

  // One-cycle start pulse; returns at the negedge after the accepting edge
  task automatic run_start(input logic [7:0] nt);
    @(negedge clk);
    start      = 1'b1;
    num_trials = nt;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_trials = '0;
    repeat (3) @(negedge clk);
    check("rst_path_input", 64'(path_input), 64'd0);
    check("rst_cnt_ld",     64'(cnt_ld),     64'd0);
    check("rst_busy",       64'(busy),       64'd0);
    check("rst_done",       64'(done),       64'd0);
    check("rst_sum",        64'(sum_out),    64'd0);
    check("rst_trials",     64'(trials_done), 64'd0);
    check("rst_timeout",    64'(timeout_err), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Non-inverting D=5, four trials from counter 0: deltas of 8
    dly = 5; inv = 1'b0;
    run_start(8'd4);
    check("r1_busy", 64'(busy), 64'd1);
    wait_done("r1_done", 400);
    check("r1_sum",     64'(sum_out),     64'd32);
    check("r1_trials",  64'(trials_done), 64'd4);
    check("r1_timeout", 64'(timeout_err), 64'd0);
    check("r1_busy_end", 64'(busy),       64'd0);
    @(negedge clk);
    check("r1_done_pulse", 64'(done), 64'd0);
    check("r1_sum_held",   64'(sum_out), 64'd32);
    repeat (20) @(negedge clk);

    // Inverting D=2, single trial: baseline 1, delta 5
    inv = 1'b1; dly = 2;
    repeat (20) @(negedge clk);
    run_start(8'd1);
    wait_done("r2_done", 200);
    check("r2_sum",    64'(sum_out),     64'd5);
    check("r2_trials", 64'(trials_done), 64'd1);
    inv = 1'b0;
    repeat (20) @(negedge clk);

    // Counter wrap: snapshot 0xFFFFFFFE, D=5 -> delta 8
    dly = 5;
    @(negedge clk); preset_req = 1'b1; preset_val = 32'hFFFF_FFFE;
    @(negedge clk); preset_req = 1'b0;
    run_start(8'd1);
    wait_done("r3_done", 200);
    check("r3_sum_wrap", 64'(sum_out), 64'd8);
    check("r3_cnt_wrapped", 64'(cnt_value), 64'd6);
    repeat (5) @(negedge clk);

    // Stuck-at-0 path: timeout after TIMEOUT wait cycles, trial discarded
    stuck = 1'b1;
    run_start(8'd3);
    wait_done("r4_done", 1200);
    check("r4_timeout", 64'(timeout_err), 64'd1);
    check("r4_trials",  64'(trials_done), 64'd0);
    check("r4_sum",     64'(sum_out),     64'd0);
    check("r4_busy",    64'(busy),        64'd0);
    @(negedge clk);
    check("r4_done_pulse",  64'(done), 64'd0);
    check("r4_timeout_sticky", 64'(timeout_err), 64'd1);
    stuck = 1'b0;
    repeat (20) @(negedge clk);

    // num_trials=0: IDLE goes straight to DONE; start held into DONE is ignored
    @(negedge clk);
    start = 1'b1; num_trials = 8'd0;
    @(negedge clk);
    check("r5_done",       64'(done),        64'd1);
    check("r5_timeout_clr", 64'(timeout_err), 64'd0);
    check("r5_sum",        64'(sum_out),     64'd0);
    check("r5_trials",     64'(trials_done), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("r5_start_in_done", 64'(done), 64'd0);
    check("r5_busy_idle",     64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    // start pulse during WAIT must not restart or relatch num_trials
    dly = 5;
    run_start(8'd2);
    wait_cnt_ld("r6_wait_entry");
    repeat (2) @(negedge clk);
    start = 1'b1; num_trials = 8'd9;
    @(negedge clk);
    start = 1'b0; num_trials = 8'd2;
    wait_done("r6_done", 400);
    check("r6_trials", 64'(trials_done), 64'd2);
    check("r6_sum",    64'(sum_out),     64'd16);
    repeat (5) @(negedge clk);

    // Reset in WAIT of the second trial returns everything to reset values
    run_start(8'd2);
    wait_trials("r7_first_trial", 8'd1);
    wait_cnt_ld("r7_wait_entry");
    repeat (2) @(negedge clk);
    check("r7_pre_sum",  64'(sum_out), 64'd8);
    check("r7_pre_busy", 64'(busy),    64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("r7_path_input", 64'(path_input), 64'd0);
    check("r7_cnt_ld",     64'(cnt_ld),     64'd0);
    check("r7_busy",       64'(busy),       64'd0);
    check("r7_sum",        64'(sum_out),    64'd0);
    check("r7_trials",     64'(trials_done), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("r7_no_done", 64'(done), 64'd0);
    repeat (5) @(negedge clk);

`ifdef DELAY_MEAS_MINMAX_EN
    // Per-trial delays 3,7,5 -> deltas 6,10,8
    dly = 3;
    run_start(8'd3);
    check("mm_min_init", 64'(min_delay), 64'hFFFF_FFFF);
    check("mm_max_init", 64'(max_delay), 64'd0);
    wait_trials("mm_trial1", 8'd1);
    dly = 7;
    wait_trials("mm_trial2", 8'd2);
    dly = 5;
    wait_done("mm_done", 400);
    check("mm_sum", 64'(sum_out),   64'd24);
    check("mm_min", 64'(min_delay), 64'd6);
    check("mm_max", 64'(max_delay), 64'd10);
    repeat (3) @(negedge clk);
    check("mm_min_held", 64'(min_delay), 64'd6);
    check("mm_max_held", 64'(max_delay), 64'd10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
